// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if: BCD word input and binary result output val/rdy handshakes.
interface bcd_to_binary_seq_if #(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_WIDTH  = 7
);
  logic                    in_val;
  logic                    in_rdy;
  logic [4*NUM_DIGITS-1:0] in_bcd;
  logic                    out_val;
  logic                    out_rdy;
  logic [BIN_WIDTH-1:0]    out_bin;
  logic                    out_err;
  modport master (output in_val, in_bcd, out_rdy, input in_rdy, out_val, out_bin, out_err);
  modport slave  (input in_val, in_bcd, out_rdy, output in_rdy, out_val, out_bin, out_err);
endinterface

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: iterative BCD-to-binary converter, one digit per cycle, MSD first.
// BCD_TO_BIN_DIGIT_CHECK_EN enables invalid-digit detection (out_err, out_bin forced to 0).
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_WIDTH  = 7
) (
  input logic               clk,
  input logic               rst_n,
  bcd_to_binary_seq_if.slave bus
);
  localparam int CW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t               state, state_nxt;
  logic [DW-1:0]        sh;
  logic [CW-1:0]        cnt;
  logic [BIN_WIDTH-1:0] acc;
  logic [3:0]           digit;
  logic [BIN_WIDTH+3:0] wide;
  logic                 err;
  logic                 take;
  assign take  = state == IDLE && bus.in_val;
  // The latched word shifts left so the digit being folded is always on top.
  assign digit = sh[DW-1 -: 4];
  assign wide  = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {{BIN_WIDTH{1'b0}}, digit};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt   = take ? CALC
                : (state == CALC && cnt == '0) ? DONE
                : (state == DONE && bus.out_rdy) ? IDLE
                : state;
    bus.in_rdy  = rst_n && state == IDLE;
    bus.out_val = state == DONE;
    bus.out_bin = (state == DONE && !err) ? acc : '0;
    bus.out_err = state == DONE && err;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
      acc <= '0;
    end else if (take) begin
      sh  <= bus.in_bcd;
      cnt <= CW'(NUM_DIGITS - 1);
      acc <= '0;
    end else if (state == CALC) begin
      sh  <= sh << 4;
      cnt <= cnt - 1'b1;
      acc <= wide[BIN_WIDTH-1:0];
    end
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              err <= 1'b0;
    else if (take)           err <= 1'b0;
    else if (state == CALC)  err <= err | (digit > 4'd9);
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: table-driven and scoreboard-checked bench for the 2-digit converter.
module tb_bcd_to_binary_seq;
  localparam int ND = 2;
  localparam int BW = 7;
  typedef struct {logic [7:0] bcd; logic [6:0] bin; logic err;} vec_t;
  typedef struct {logic [6:0] bin; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bcd_to_binary_seq_if #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) bus();
  bcd_to_binary_seq #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t q[$];
  exp_t cur;
  vec_t vecs[7];
  int checks = 0;
  int errors = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask
  function automatic exp_t model(logic [7:0] b);
    exp_t r;
    int v;
    logic bad;
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    bad = b[7:4] > 4'd9 || b[3:0] > 4'd9;
    r.bin = v[6:0];
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    r.err = bad;
    if (bad) r.bin = '0;
`else
    r.err = 1'b0;
`endif
    return r;
  endfunction
  // Sample handshakes just before the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.in_val && bus.in_rdy) q.push_back(cur);
    if (bus.out_val && bus.out_rdy) begin
      if (q.size() == 0) chk("unexpected_out", int'(bus.out_bin), -1);
      else begin
        e = q.pop_front();
        chk("out_bin", int'(bus.out_bin), int'(e.bin));
        chk("out_err", int'(bus.out_err), int'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] b, exp_t e);
    int n = 0;
    while (!bus.in_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_rdy) chk("in_rdy_timeout", int'(bus.in_rdy), 1);
    bus.in_val = 1'b1;
    bus.in_bcd = b;
    cur = e;
    tick();
    bus.in_val = 1'b0;
    bus.in_bcd = 'x;
  endtask
  task automatic drain();
    int n = 0;
    bus.out_rdy = 1'b1;
    while (q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask
  initial begin
    exp_t e;
    int n;
    vecs[0] = '{8'h00, 7'd0, 1'b0};
    vecs[1] = '{8'h99, 7'd99, 1'b0};
    vecs[4] = '{8'h09, 7'd9, 1'b0};
    vecs[5] = '{8'h90, 7'd90, 1'b0};
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    vecs[2] = '{8'h4A, 7'd0, 1'b1};
    vecs[3] = '{8'hF0, 7'd0, 1'b1};
    vecs[6] = '{8'hA5, 7'd0, 1'b1};
`else
    vecs[2] = '{8'h4A, 7'd50, 1'b0};
    vecs[3] = '{8'hF0, 7'd22, 1'b0};
    vecs[6] = '{8'hA5, 7'd105, 1'b0};
`endif
    bus.in_val = 1'b0;
    bus.in_bcd = 'x;
    bus.out_rdy = 1'b0;
    #12;
    chk("rst_in_rdy", int'(bus.in_rdy), 0);
    chk("rst_out_val", int'(bus.out_val), 0);
    chk("rst_out_bin", int'(bus.out_bin), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_rdy", int'(bus.in_rdy), 1);
    @(posedge clk);
    #1;
    send(8'h42, model(8'h42));
    chk("lat_e0_out_val", int'(bus.out_val), 0);
    tick();
    chk("lat_e1_out_val", int'(bus.out_val), 0);
    tick();
    chk("lat_e2_out_val", int'(bus.out_val), 1);
    chk("lat_e2_out_bin", int'(bus.out_bin), 42);
    chk("lat_e2_out_err", int'(bus.out_err), 0);
    chk("lat_e2_in_rdy", int'(bus.in_rdy), 0);
    bus.out_rdy = 1'b1;
    tick();
    chk("after_out_val", int'(bus.out_val), 0);
    chk("after_in_rdy", int'(bus.in_rdy), 1);
    for (int t = 0; t < 10; t++)
      for (int o = 0; o < 10; o++) begin
        logic [7:0] b;
        b = {4'(t), 4'(o)};
        send(b, model(b));
      end
    drain();
    for (int i = 0; i < 7; i++) begin
      e.bin = vecs[i].bin;
      e.err = vecs[i].err;
      send(vecs[i].bcd, e);
    end
    drain();
    bus.out_rdy = 1'b0;
    send(8'h57, model(8'h57));
    n = 0;
    while (!bus.out_val && n < 20) begin
      tick();
      n++;
    end
    chk("bp_out_val_wait", int'(bus.out_val), 1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_val", int'(bus.out_val), 1);
      chk("bp_out_bin", int'(bus.out_bin), 57);
      chk("bp_in_rdy", int'(bus.in_rdy), 0);
      tick();
    end
    bus.out_rdy = 1'b1;
    tick();
    chk("bp_release_out_val", int'(bus.out_val), 0);
    bus.out_rdy = 1'b0;
    send(8'h12, model(8'h12));
    bus.in_val = 1'b1;
    bus.in_bcd = 8'h88;
    cur = model(8'h88);
    for (int k = 0; k < 4; k++) tick();
    chk("busy_hold_bin", int'(bus.out_bin), 12);
    chk("busy_queue_len", q.size(), 1);
    bus.out_rdy = 1'b1;
    tick();
    tick();
    bus.in_val = 1'b0;
    bus.in_bcd = 'x;
    drain();
    send(8'h77, model(8'h77));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_rdy", int'(bus.in_rdy), 0);
    chk("arst_out_val", int'(bus.out_val), 0);
    chk("arst_out_bin", int'(bus.out_bin), 0);
    q.delete();
    @(posedge clk);
    #2;
    chk("arst_hold_out_val", int'(bus.out_val), 0);
    rst_n = 1'b1;
    #1;
    chk("arst_release_in_rdy", int'(bus.in_rdy), 1);
    @(posedge clk);
    #1;
    send(8'h31, model(8'h31));
    drain();
    chk("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
